// File: rtl/DualPortRam.sv
// Simple dual-port RAM: port A writes, port B performs registered reads.
// Each port runs on its own clock and contents are never cleared.
module DualPortRam #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk_a,
  input  logic                     en_a,
  input  logic                     we_a,
  input  logic [ADDRESS_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0]    din_a,
  input  logic                     clk_b,
  input  logic                     en_b,
  input  logic [ADDRESS_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0]    dout_b
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_a) begin
    if (en_a && we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk_b) begin
    if (en_b) begin
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO built around one DualPortRam.
// The RAM read register doubles as the output stage, so capacity is DEPTH+1.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [ADDRESS_WIDTH:0] level
);

  localparam int PTR_W = ADDRESS_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic             mValid_q, mValid_d;
  logic [PTR_W-1:0] ramCount;
  logic             active;
  logic             push;
  logic             pop;
  logic             readEn;

  // Pointers carry one extra bit so full (count == DEPTH) differs from empty.
  always_comb begin
    active   = ~rst & ~flush;
    ramCount = wrPtr_q - rdPtr_q;
    s_ready  = (ramCount < FULL_COUNT) & active;
    push     = s_valid & s_ready;
    pop      = mValid_q & m_ready;
    readEn   = active & (ramCount != '0) & (~mValid_q | m_ready);
  end

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    mValid_d = mValid_q;
    if (flush) begin
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      mValid_d = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (readEn) begin
        rdPtr_d  = rdPtr_q + PTR_W'(1);
        mValid_d = 1'b1;
      end else if (pop) begin
        mValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      mValid_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      mValid_q <= mValid_d;
    end
  end

  assign m_valid = mValid_q;
  assign level   = ramCount + {{ADDRESS_WIDTH{1'b0}}, mValid_q};

  DualPortRam #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) uRam (
    .clk_a  (clk),
    .en_a   (push),
    .we_a   (push),
    .addr_a (wrPtr_q[ADDRESS_WIDTH-1:0]),
    .din_a  (s_data),
    .clk_b  (clk),
    .en_b   (readEn),
    .addr_b (rdPtr_q[ADDRESS_WIDTH-1:0]),
    .dout_b (m_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and randomized bench for ram_fifo_ctrl, scored against a queue model
// holding every word accepted and not yet consumed.
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW:0]   level;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] model[$];
  logic          prevHold = 1'b0;
  logic [DW-1:0] prevData = '0;
  int            pushCount = 0;
  int            popCount = 0;
  logic [DW-1:0] firstPopped = '0;
  logic          sawFirstPop = 1'b0;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, settle, score the handshakes, cross the edge, check level.
  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic mr,
                               input logic fl, input logic rs);
    logic obsReady, obsValid, didPush, didPop;
    logic [DW-1:0] obsData;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    rst     = rs;
    #1;
    obsReady = s_ready;
    obsValid = m_valid;
    obsData  = m_data;
    if (prevHold && obsValid) checkOutput("hold_stable", {24'd0, obsData}, {24'd0, prevData});
    if (rs || fl) begin
      checkOutput("ready_blocked", {31'd0, obsReady}, 32'd0);
      model.delete();
      prevHold = 1'b0;
    end else begin
      didPush = sv & obsReady;
      didPop  = obsValid & mr;
      if (didPop) begin
        if (model.size() == 0) begin
          checkOutput("pop_from_empty", 32'd1, 32'd0);
        end else begin
          checkOutput("pop_data", {24'd0, obsData}, {24'd0, model[0]});
          if (!sawFirstPop) begin
            firstPopped = obsData;
            sawFirstPop = 1'b1;
          end
          void'(model.pop_front());
        end
        popCount++;
      end
      if (didPush) begin
        model.push_back(sd);
        pushCount++;
      end
      prevHold = obsValid & ~mr;
      prevData = obsData;
    end
    @(posedge clk);
    #1;
    checkOutput("level", {28'd0, level}, model.size());
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((model.size() != 0 || m_valid === 1'b1) && budget < 60) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      budget++;
    end
    checkOutput("drain_done", {31'd0, m_valid}, 32'd0);
    checkOutput("drain_level", {28'd0, level}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int cycles;

    // Reset state
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("reset_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("reset_s_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("reset_level", {28'd0, level}, 32'd0);

    // Three words with a stalled consumer: two-edge latency, head held
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_first_edge", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_second_edge", {31'd0, m_valid}, 32'd1);
    checkOutput("lat_head", {24'd0, m_data}, 32'h11);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("three_level", {28'd0, level}, 32'd3);
    checkOutput("three_head", {24'd0, m_data}, 32'h11);
    drain();

    // Fill to DEPTH+1 and drain in order
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("full_level", {28'd0, level}, 32'd9);
    checkOutput("full_ready", {31'd0, s_ready}, 32'd0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkOutput("full_no_accept", {28'd0, level}, 32'd9);
    sawFirstPop = 1'b0;
    drain();
    checkOutput("full_first_out", {24'd0, firstPopped}, 32'h01);

    // Continuous streaming across pointer wrap
    pushCount = 0;
    popCount = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      if (i >= 2) checkOutput("stream_pop", popCount, i - 1);
    end
    checkOutput("stream_pushes", pushCount, 40);
    drain();

    // Flush with five words stored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_m_valid", {31'd0, m_valid}, 32'd0);
    flush = 1'b0;
    #1;
    checkOutput("flush_ready", {31'd0, s_ready}, 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    sawFirstPop = 1'b0;
    drain();
    checkOutput("flush_first_out", {24'd0, firstPopped}, 32'hAA);

    // Randomized traffic for 1000 words
    pushCount = 0;
    popCount = 0;
    cycles = 0;
    while (pushCount < 1000 && cycles < 20000) begin
      d = DW'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cycles++;
    end
    checkOutput("random_pushes", pushCount, 1000);
    drain();
    checkOutput("random_pops", popCount, 1000);

    // Reset mid-stream at level 6
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_level", {28'd0, level}, 32'd6);
    applyStimulus(1'b1, 8'hE0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hE1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_level", {28'd0, level}, 32'd0);
    checkOutput("post_reset_valid", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("no_stale_word", {31'd0, m_valid}, 32'd0);
    applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    sawFirstPop = 1'b0;
    drain();
    checkOutput("post_reset_first", {24'd0, firstPopped}, 32'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
